gps_corr_dump_capture: RTL and testbench

- Sits directly downstream of gps_ca_correlator_channel.
- On each correlator dump it latches the Early/Prompt/Late I/Q accumulations and dump_count.
- Computes the three powers (I²+Q²) using one shared multiplier over several cycles.
- Queues complete records in a small FIFO and presents them on a valid/ready stream to the tracking-loop CPU interface.

---
 rtl/gps_dump_pkg.sv | 46 ++++
 rtl/gps_dump_fifo.sv | 90 +++++++++
 rtl/gps_corr_dump_capture.sv | 208 ++++++++++++++++++++
 tb/tb_gps_corr_dump_capture.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gps_dump_pkg.sv
// Shared types for the correlator dump capture block.
// GPS_DUMP_TIMESTAMP_EN adds a 48-bit sample timestamp field to each record.
package gps_dump_pkg;

  localparam int unsigned ACC_W  = 18;
  localparam int unsigned SQ_W   = 2 * ACC_W;
  localparam int unsigned POW_W  = 2 * ACC_W;
  localparam int unsigned DCNT_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned TS_W   = 48;

  localparam logic [CNT_W-1:0] CNT_SAT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQ0  = 3'd1,
    SQ1  = 3'd2,
    SQ2  = 3'd3,
    SQ3  = 3'd4,
    SQ4  = 3'd5,
    SQ5  = 3'd6,
    PUSH = 3'd7
  } state_e;

  // One complete dump record as it travels through the FIFO.
  typedef struct packed {
`ifdef GPS_DUMP_TIMESTAMP_EN
    logic [TS_W-1:0]   timestamp;
`endif
    logic [DCNT_W-1:0] dump_count;
    logic [ACC_W-1:0]  ie;
    logic [ACC_W-1:0]  qe;
    logic [ACC_W-1:0]  ip;
    logic [ACC_W-1:0]  qp;
    logic [ACC_W-1:0]  il;
    logic [ACC_W-1:0]  ql;
    logic [POW_W-1:0]  pe;
    logic [POW_W-1:0]  pp;
    logic [POW_W-1:0]  pl;
  } dump_rec_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/gps_dump_fifo.sv
// First-word-fall-through record FIFO with a registered head and level.
// Head fields hold their last value while empty; extra pointer bit separates full from empty.
module gps_dump_fifo
  import gps_dump_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clr,
  input  logic                   i_push,
  input  dump_rec_t              i_data,
  input  logic                   i_pop,
  output dump_rec_t              o_head,
  output logic                   o_valid,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_reject_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  dump_rec_t     r_mem [DEPTH];
  dump_rec_t     r_head;
  dump_rec_t     w_head_n;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_level;
  logic          r_valid;
  logic [PW-1:0] w_level;
  logic [PW-1:0] w_level_n;
  logic [PW-1:0] w_wr_ptr_n;
  logic [PW-1:0] w_rd_ptr_n;
  logic          w_full;
  logic          w_pop;
  logic          w_push_ok;

  assign w_level    = r_wr_ptr - r_rd_ptr;
  assign w_full     = (w_level == PW'(DEPTH));
  assign w_pop      = i_pop & r_valid;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push_ok  = i_push & (~w_full | w_pop);
  assign o_reject_c = i_push & ~w_push_ok;
  assign w_wr_ptr_n = r_wr_ptr + PW'(w_push_ok);
  assign w_rd_ptr_n = r_rd_ptr + PW'(w_pop);
  assign w_level_n  = w_wr_ptr_n - w_rd_ptr_n;

  // Next head bypasses storage when it is the record being written right now.
  always_comb begin
    w_head_n = r_mem[w_rd_ptr_n[AW-1:0]];
    if (w_push_ok && (w_rd_ptr_n[AW-1:0] == r_wr_ptr[AW-1:0])) begin
      w_head_n = i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_valid  <= 1'b0;
      r_head   <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_valid  <= 1'b0;
      r_head   <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_n;
      r_rd_ptr <= w_rd_ptr_n;
      r_level  <= w_level_n;
      r_valid  <= (w_level_n != '0);
      if (w_level_n != '0) begin
        r_head <= w_head_n;
      end
    end
  end

  assign o_head  = r_head;
  assign o_valid = r_valid;
  assign o_level = r_level;

endmodule

// File: rtl/gps_corr_dump_capture.sv
// Captures correlator E/P/L dumps, squares them through one shared multiplier
// and queues records to the tracking CPU. GPS_DUMP_TIMESTAMP_EN adds rec_timestamp.
module gps_corr_dump_capture
  import gps_dump_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr,
  input  logic                    dump,
  input  logic [DCNT_W-1:0]       dump_count,
  input  logic signed [ACC_W-1:0] i_early,
  input  logic signed [ACC_W-1:0] q_early,
  input  logic signed [ACC_W-1:0] i_prompt,
  input  logic signed [ACC_W-1:0] q_prompt,
  input  logic signed [ACC_W-1:0] i_late,
  input  logic signed [ACC_W-1:0] q_late,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [DCNT_W-1:0]       rec_dump_count,
  output logic signed [ACC_W-1:0] rec_ie,
  output logic signed [ACC_W-1:0] rec_qe,
  output logic signed [ACC_W-1:0] rec_ip,
  output logic signed [ACC_W-1:0] rec_qp,
  output logic signed [ACC_W-1:0] rec_il,
  output logic signed [ACC_W-1:0] rec_ql,
  output logic [POW_W-1:0]        rec_pe,
  output logic [POW_W-1:0]        rec_pp,
  output logic [POW_W-1:0]        rec_pl,
`ifdef GPS_DUMP_TIMESTAMP_EN
  output logic [TS_W-1:0]         rec_timestamp,
`endif
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic [CNT_W-1:0]        drop_count,
  output logic [CNT_W-1:0]        ovf_count,
  output logic                    ovf_sticky
);

  state_e                  r_state;
  state_e                  w_state_n;
  dump_rec_t               r_rec;
  dump_rec_t               w_head;
  logic                    w_load;
  logic                    w_drop;
  logic                    w_push;
  logic                    w_reject;
  logic signed [ACC_W-1:0] w_op;
  logic signed [SQ_W-1:0]  w_sq;
  logic [POW_W-1:0]        w_sq_u;
  logic [CNT_W-1:0]        r_drop_cnt;
  logic [CNT_W-1:0]        r_ovf_cnt;
  logic                    r_ovf_sticky;
`ifdef GPS_DUMP_TIMESTAMP_EN
  logic [TS_W-1:0]         r_ts;
`endif

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else if (clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Fixed seven-cycle walk once a dump has been accepted.
  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      IDLE:    if (dump) w_state_n = SQ0;
      SQ0:     w_state_n = SQ1;
      SQ1:     w_state_n = SQ2;
      SQ2:     w_state_n = SQ3;
      SQ3:     w_state_n = SQ4;
      SQ4:     w_state_n = SQ5;
      SQ5:     w_state_n = PUSH;
      PUSH:    w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  // Per-state controls and multiplier operand select.
  always_comb begin
    w_load = 1'b0;
    w_drop = 1'b0;
    w_push = 1'b0;
    w_op   = '0;
    unique case (r_state)
      IDLE:    w_load = dump;
      SQ0:     w_op   = r_rec.ie;
      SQ1:     w_op   = r_rec.qe;
      SQ2:     w_op   = r_rec.ip;
      SQ3:     w_op   = r_rec.qp;
      SQ4:     w_op   = r_rec.il;
      SQ5:     w_op   = r_rec.ql;
      PUSH:    w_push = 1'b1;
      default: w_op   = '0;
    endcase
    if (dump && (r_state != IDLE)) begin
      w_drop = 1'b1;
    end
  end

  // Shared squarer; the square of a signed value is never negative.
  assign w_sq   = SQ_W'(w_op) * SQ_W'(w_op);
  assign w_sq_u = POW_W'($unsigned(w_sq));

  // Capture registers and power accumulators.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rec <= '0;
    end else if (clr) begin
      r_rec <= '0;
    end else begin
      if (w_load) begin
        r_rec.dump_count <= dump_count;
        r_rec.ie         <= i_early;
        r_rec.qe         <= q_early;
        r_rec.ip         <= i_prompt;
        r_rec.qp         <= q_prompt;
        r_rec.il         <= i_late;
        r_rec.ql         <= q_late;
`ifdef GPS_DUMP_TIMESTAMP_EN
        r_rec.timestamp  <= r_ts;
`endif
      end
      unique case (r_state)
        SQ0:     r_rec.pe <= w_sq_u;
        SQ1:     r_rec.pe <= r_rec.pe + w_sq_u;
        SQ2:     r_rec.pp <= w_sq_u;
        SQ3:     r_rec.pp <= r_rec.pp + w_sq_u;
        SQ4:     r_rec.pl <= w_sq_u;
        SQ5:     r_rec.pl <= r_rec.pl + w_sq_u;
        default: ;
      endcase
    end
  end

  // Drop / overflow bookkeeping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_drop_cnt   <= '0;
      r_ovf_cnt    <= '0;
      r_ovf_sticky <= 1'b0;
    end else if (clr) begin
      r_drop_cnt   <= '0;
      r_ovf_cnt    <= '0;
      r_ovf_sticky <= 1'b0;
    end else begin
      if (w_drop) begin
        r_drop_cnt <= sat_inc(r_drop_cnt);
      end
      if (w_reject) begin
        r_ovf_cnt    <= sat_inc(r_ovf_cnt);
        r_ovf_sticky <= 1'b1;
      end
    end
  end

`ifdef GPS_DUMP_TIMESTAMP_EN
  // Free-running sample counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ts <= '0;
    end else if (clr) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
    end
  end
`endif

  gps_dump_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (clr),
    .i_push     (w_push),
    .i_data     (r_rec),
    .i_pop      (rec_ready),
    .o_head     (w_head),
    .o_valid    (rec_valid),
    .o_level    (fifo_level),
    .o_reject_c (w_reject)
  );

  assign rec_dump_count = w_head.dump_count;
  assign rec_ie         = w_head.ie;
  assign rec_qe         = w_head.qe;
  assign rec_ip         = w_head.ip;
  assign rec_qp         = w_head.qp;
  assign rec_il         = w_head.il;
  assign rec_ql         = w_head.ql;
  assign rec_pe         = w_head.pe;
  assign rec_pp         = w_head.pp;
  assign rec_pl         = w_head.pl;
`ifdef GPS_DUMP_TIMESTAMP_EN
  assign rec_timestamp  = w_head.timestamp;
`endif
  assign drop_count     = r_drop_cnt;
  assign ovf_count      = r_ovf_cnt;
  assign ovf_sticky     = r_ovf_sticky;

endmodule

// File: tb/tb_gps_corr_dump_capture.sv
// Bench for gps_corr_dump_capture: queue-based record model checked every cycle,
// plus directed literal checks for each scenario.
module tb_gps_corr_dump_capture;

  localparam int unsigned AW    = 18;
  localparam int unsigned PW    = 36;
  localparam int unsigned DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 clr = 1'b0;
  logic                 dump = 1'b0;
  logic                 rec_ready = 1'b0;
  logic [31:0]          dump_count = '0;
  logic signed [AW-1:0] i_early = '0, q_early = '0, i_prompt = '0;
  logic signed [AW-1:0] q_prompt = '0, i_late = '0, q_late = '0;
  logic                 rec_valid;
  logic [31:0]          rec_dump_count;
  logic signed [AW-1:0] rec_ie, rec_qe, rec_ip, rec_qp, rec_il, rec_ql;
  logic [PW-1:0]        rec_pe, rec_pp, rec_pl;
`ifdef GPS_DUMP_TIMESTAMP_EN
  logic [47:0]          rec_timestamp;
`endif
  logic [2:0]           fifo_level;
  logic [15:0]          drop_count, ovf_count;
  logic                 ovf_sticky;

  always #5 clk = ~clk;

  gps_corr_dump_capture #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .clr            (clr),
    .dump           (dump),
    .dump_count     (dump_count),
    .i_early        (i_early),
    .q_early        (q_early),
    .i_prompt       (i_prompt),
    .q_prompt       (q_prompt),
    .i_late         (i_late),
    .q_late         (q_late),
    .rec_valid      (rec_valid),
    .rec_ready      (rec_ready),
    .rec_dump_count (rec_dump_count),
    .rec_ie         (rec_ie),
    .rec_qe         (rec_qe),
    .rec_ip         (rec_ip),
    .rec_qp         (rec_qp),
    .rec_il         (rec_il),
    .rec_ql         (rec_ql),
    .rec_pe         (rec_pe),
    .rec_pp         (rec_pp),
    .rec_pl         (rec_pl),
`ifdef GPS_DUMP_TIMESTAMP_EN
    .rec_timestamp  (rec_timestamp),
`endif
    .fifo_level     (fifo_level),
    .drop_count     (drop_count),
    .ovf_count      (ovf_count),
    .ovf_sticky     (ovf_sticky)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: records in flight and in the queue, described by arithmetic only.
  typedef struct {
    longint dc, ie, qe, ip, qp, il, ql, pe, pp, pl;
  } mrec_t;

  mrec_t  mq[$];
  mrec_t  hold;
  mrec_t  pend_rec;
  bit     pend = 1'b0;
  int     pend_at = 0;
  int     cyc = 0;
  int     m_drop = 0;
  int     m_ovf = 0;
  bit     m_sticky = 1'b0;
  bit     armed = 1'b0;

  function automatic logic [255:0] pack_rec(input mrec_t r);
    return {8'h0, 32'(r.dc), 18'(r.ie), 18'(r.qe), 18'(r.ip), 18'(r.qp), 18'(r.il),
            18'(r.ql), 36'(r.pe), 36'(r.pp), 36'(r.pl)};
  endfunction

  task automatic model_reset();
    mq.delete();
    hold     = '{default: 0};
    pend     = 1'b0;
    m_drop   = 0;
    m_ovf    = 0;
    m_sticky = 1'b0;
  endtask

  task automatic model_step();
    bit busy;
    bit pop;
    if (clr) begin
      model_reset();
      return;
    end
    cyc++;
    busy = pend;
    pop  = (mq.size() > 0) && rec_ready;
    if (pend && cyc == pend_at) begin
      pend = 1'b0;
      if (mq.size() == DEPTH && !pop) begin
        if (m_ovf < 65535) m_ovf++;
        m_sticky = 1'b1;
      end else begin
        if (pop) begin
          void'(mq.pop_front());
          pop = 1'b0;
        end
        mq.push_back(pend_rec);
      end
    end
    if (pop) void'(mq.pop_front());
    if (dump) begin
      if (busy) begin
        if (m_drop < 65535) m_drop++;
      end else begin
        pend     = 1'b1;
        pend_at  = cyc + 7;
        pend_rec = '{dc: longint'(dump_count),
                     ie: longint'(i_early),  qe: longint'(q_early),
                     ip: longint'(i_prompt), qp: longint'(q_prompt),
                     il: longint'(i_late),   ql: longint'(q_late),
                     pe: longint'(i_early) * longint'(i_early) + longint'(q_early) * longint'(q_early),
                     pp: longint'(i_prompt) * longint'(i_prompt) + longint'(q_prompt) * longint'(q_prompt),
                     pl: longint'(i_late) * longint'(i_late) + longint'(q_late) * longint'(q_late)};
      end
    end
    if (mq.size() > 0) hold = mq[0];
  endtask

  task automatic model_compare();
    chk("rec_valid", 256'(rec_valid), 256'(mq.size() > 0));
    chk("fifo_level", 256'(fifo_level), 256'(mq.size()));
    chk("drop_count", 256'(drop_count), 256'(m_drop));
    chk("ovf_count", 256'(ovf_count), 256'(m_ovf));
    chk("ovf_sticky", 256'(ovf_sticky), 256'(m_sticky));
    chk("head_record",
        {8'h0, rec_dump_count, rec_ie, rec_qe, rec_ip, rec_qp, rec_il, rec_ql,
         rec_pe, rec_pp, rec_pl},
        pack_rec(hold));
  endtask

  // Compare process: advance the model at each edge, check just after it.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      model_reset();
    end else begin
      model_step();
      #1;
      if (armed) model_compare();
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_dump(input int dc, input int ie, input int qe, input int ip,
                         input int qp, input int il, input int ql);
    @(negedge clk);
    dump       = 1'b1;
    dump_count = 32'(dc);
    i_early    = AW'(ie);
    q_early    = AW'(qe);
    i_prompt   = AW'(ip);
    q_prompt   = AW'(qp);
    i_late     = AW'(il);
    q_late     = AW'(ql);
    @(negedge clk);
    dump = 1'b0;
  endtask

  task automatic pop_one();
    rec_ready = 1'b1;
    wait_cyc(1);
    rec_ready = 1'b0;
  endtask

  initial begin
    // Reset values
    wait_cyc(3);
    chk("rst_valid", 256'(rec_valid), 256'(0));
    chk("rst_level", 256'(fifo_level), 256'(0));
    chk("rst_drop", 256'(drop_count), 256'(0));
    chk("rst_ovf", 256'(ovf_count), 256'(0));
    chk("rst_sticky", 256'(ovf_sticky), 256'(0));
    chk("rst_pe", 256'(rec_pe), 256'(0));
    rstn  = 1'b1;
    armed = 1'b1;
    wait_cyc(2);

    // Single dump: record appears exactly 7 edges after acceptance
    do_dump(7, 3, -4, 100, 0, -5, 12);
    wait_cyc(6);
    chk("single_early_valid", 256'(rec_valid), 256'(0));
    wait_cyc(1);
    chk("single_valid", 256'(rec_valid), 256'(1));
    chk("single_dc", 256'(rec_dump_count), 256'(7));
    chk("single_qe", 256'(rec_qe), 256'(-4));
    chk("single_pe", 256'(rec_pe), 256'(25));
    chk("single_pp", 256'(rec_pp), 256'(10000));
    chk("single_pl", 256'(rec_pl), 256'(169));
    chk("single_level", 256'(fifo_level), 256'(1));
    pop_one();

    // Extremes: most negative inputs everywhere
    do_dump(8, -131072, -131072, -131072, -131072, -131072, -131072);
    wait_cyc(7);
    chk("ext_pe", 256'(rec_pe), 256'h8_0000_0000);
    chk("ext_pp", 256'(rec_pp), 256'h8_0000_0000);
    chk("ext_pl", 256'(rec_pl), 256'h8_0000_0000);
    pop_one();

    // Busy drop: second dump three cycles after the first
    do_dump(9, 1, 2, 3, 4, 5, 6);
    wait_cyc(1);
    do_dump(10, 9, 9, 9, 9, 9, 9);
    wait_cyc(10);
    chk("busy_drop", 256'(drop_count), 256'(1));
    chk("busy_level", 256'(fifo_level), 256'(1));
    chk("busy_dc", 256'(rec_dump_count), 256'(9));
    pop_one();

    // Overflow: five dumps, 20 cycles apart, nothing consumed
    for (int k = 0; k < 5; k++) begin
      do_dump(100 + k, k, -k, 2 * k, 300 - k, -1000 * k, 7);
      wait_cyc(18);
    end
    chk("ovf_level", 256'(fifo_level), 256'(4));
    chk("ovf_count", 256'(ovf_count), 256'(1));
    chk("ovf_sticky", 256'(ovf_sticky), 256'(1));
    chk("ovf_head", 256'(rec_dump_count), 256'(100));

    // Full FIFO with a pop on the PUSH edge
    do_dump(105, 11, 12, 13, 14, 15, 16);
    wait_cyc(6);
    rec_ready = 1'b1;
    wait_cyc(1);
    rec_ready = 1'b0;
    chk("fullpop_level", 256'(fifo_level), 256'(4));
    chk("fullpop_ovf", 256'(ovf_count), 256'(1));
    chk("fullpop_head", 256'(rec_dump_count), 256'(101));
    rec_ready = 1'b1;
    wait_cyc(4);
    rec_ready = 1'b0;
    chk("drain_level", 256'(fifo_level), 256'(0));
    chk("drain_last_dc", 256'(rec_dump_count), 256'(105));

    // clr while the squarer is in SQ3
    do_dump(200, 1, 1, 1, 1, 1, 1);
    wait_cyc(3);
    clr = 1'b1;
    wait_cyc(1);
    clr = 1'b0;
    wait_cyc(10);
    chk("clr_valid", 256'(rec_valid), 256'(0));
    chk("clr_level", 256'(fifo_level), 256'(0));
    chk("clr_drop", 256'(drop_count), 256'(0));
    chk("clr_ovf", 256'(ovf_count), 256'(0));
    chk("clr_sticky", 256'(ovf_sticky), 256'(0));
    chk("clr_dc", 256'(rec_dump_count), 256'(0));

    // Async reset pulse while in PUSH
    do_dump(300, 5, 5, 5, 5, 5, 5);
    wait_cyc(8);
    do_dump(301, 6, 6, 6, 6, 6, 6);
    wait_cyc(1);
    do_dump(302, 7, 7, 7, 7, 7, 7);
    chk("pre_rst_drop", 256'(drop_count), 256'(1));
    chk("pre_rst_level", 256'(fifo_level), 256'(1));
    wait_cyc(3);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_valid", 256'(rec_valid), 256'(0));
    chk("arst_level", 256'(fifo_level), 256'(0));
    chk("arst_drop", 256'(drop_count), 256'(0));
    chk("arst_dc", 256'(rec_dump_count), 256'(0));
    chk("arst_pe", 256'(rec_pe), 256'(0));
    wait_cyc(2);
    rstn = 1'b1;

    // Recovery after reset
    do_dump(400, 7, -7, 8, -8, 9, -9);
    wait_cyc(7);
    chk("recover_valid", 256'(rec_valid), 256'(1));
    chk("recover_dc", 256'(rec_dump_count), 256'(400));
    chk("recover_pl", 256'(rec_pl), 256'(162));
    pop_one();
    wait_cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
